// File: rtl/jt6295_adpcm_tdm.sv
// ---------------------------------------------------------------------------
// jt6295_adpcm_tdm
// Time-multiplexed OKI ADPCM decoder. One pipeline serves CHANNELS voices;
// each voice keeps its accumulator and step index in an internal state table.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   cen        clock enable; all state advances only when high
//   in_valid   nibble request present
//   in_ready   request can be accepted (combinational, independent of cen)
//   in_ch      channel of the request; channels >= CHANNELS are swallowed
//   in_data    ADPCM nibble, [3] sign, [2:0] magnitude
//   in_att     attenuation code 0..15
//   in_start   clear channel accumulator/index before decoding this nibble
//   out_valid  one-cen-cycle pulse per decoded sample
//   out_ch     channel of out_sound
//   out_sound  signed attenuated sample, 12-bit value left-aligned
//
// Pipeline (one stage per cen cycle):
//   S1 request -> state read + step lookup -> S2 -> diff/index/saturate,
//   state writeback -> S3 -> attenuation -> S4 -> output registers.
// ---------------------------------------------------------------------------
module jt6295_adpcm_tdm #(
    parameter int CHANNELS = 4,
    parameter int CHW      = 2,
    parameter int OUT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHW-1:0]   in_ch,
    input  logic [3:0]       in_data,
    input  logic [3:0]       in_att,
    input  logic             in_start,
    output logic             out_valid,
    output logic [CHW-1:0]   out_ch,
    output logic [OUT_W-1:0] out_sound
);

    // One bit per encodable channel index: set when the channel really exists.
    function automatic logic [2**CHW-1:0] build_ch_mask();
        logic [2**CHW-1:0] m;
        m = {(2**CHW){1'b0}};
        for (int i = 0; i < 2**CHW; i++) begin
            m[i] = (i < CHANNELS);
        end
        return m;
    endfunction

    localparam logic [2**CHW-1:0] CH_MASK = build_ch_mask();

    // 49-entry OKI step table.
    function automatic logic [10:0] step_lut(input logic [5:0] idx);
        logic [10:0] s;
        case (idx)
            6'd0:  s = 11'd16;   6'd1:  s = 11'd17;   6'd2:  s = 11'd19;   6'd3:  s = 11'd21;
            6'd4:  s = 11'd23;   6'd5:  s = 11'd25;   6'd6:  s = 11'd28;   6'd7:  s = 11'd31;
            6'd8:  s = 11'd34;   6'd9:  s = 11'd37;   6'd10: s = 11'd41;   6'd11: s = 11'd45;
            6'd12: s = 11'd50;   6'd13: s = 11'd55;   6'd14: s = 11'd60;   6'd15: s = 11'd66;
            6'd16: s = 11'd73;   6'd17: s = 11'd80;   6'd18: s = 11'd88;   6'd19: s = 11'd97;
            6'd20: s = 11'd107;  6'd21: s = 11'd118;  6'd22: s = 11'd130;  6'd23: s = 11'd143;
            6'd24: s = 11'd157;  6'd25: s = 11'd173;  6'd26: s = 11'd190;  6'd27: s = 11'd209;
            6'd28: s = 11'd230;  6'd29: s = 11'd253;  6'd30: s = 11'd279;  6'd31: s = 11'd307;
            6'd32: s = 11'd337;  6'd33: s = 11'd371;  6'd34: s = 11'd408;  6'd35: s = 11'd449;
            6'd36: s = 11'd494;  6'd37: s = 11'd544;  6'd38: s = 11'd598;  6'd39: s = 11'd658;
            6'd40: s = 11'd724;  6'd41: s = 11'd796;  6'd42: s = 11'd876;  6'd43: s = 11'd963;
            6'd44: s = 11'd1060; 6'd45: s = 11'd1166; 6'd46: s = 11'd1282; 6'd47: s = 11'd1411;
            6'd48: s = 11'd1552;
            default: s = 11'd16;
        endcase
        return s;
    endfunction

    // Attenuation gain in 1/32 units; codes 9..15 mute the voice.
    function automatic logic [5:0] gain_lut(input logic [3:0] att);
        logic [5:0] g;
        case (att)
            4'd0:    g = 6'd32;
            4'd1:    g = 6'd22;
            4'd2:    g = 6'd16;
            4'd3:    g = 6'd11;
            4'd4:    g = 6'd8;
            4'd5:    g = 6'd6;
            4'd6:    g = 6'd4;
            4'd7:    g = 6'd3;
            4'd8:    g = 6'd2;
            default: g = 6'd0;
        endcase
        return g;
    endfunction

    // Per-channel state table
    logic signed [11:0] acc_r [0:CHANNELS-1];
    logic [5:0]         idx_r [0:CHANNELS-1];

    // Stage registers
    logic               s1_v_r, s1_start_r;
    logic [CHW-1:0]     s1_ch_r;
    logic [3:0]         s1_d_r, s1_att_r;

    logic               s2_v_r;
    logic [CHW-1:0]     s2_ch_r;
    logic [3:0]         s2_d_r, s2_att_r;
    logic signed [11:0] s2_acc_r;
    logic [5:0]         s2_idx_r;
    logic [10:0]        s2_step_r;

    logic               s3_v_r;
    logic [CHW-1:0]     s3_ch_r;
    logic [3:0]         s3_att_r;
    logic signed [11:0] s3_acc_r;

    logic               s4_v_r;
    logic [CHW-1:0]     s4_ch_r;
    logic [OUT_W-1:0]   s4_snd_r;

    // Combinational stage logic
    logic               accept_s;
    logic signed [11:0] s1_acc_s;
    logic [5:0]         s1_idx_s;
    logic signed [11:0] rd_acc_s;
    logic [5:0]         rd_idx_s;
    logic [11:0]        diff_s;
    logic signed [6:0]  inc_s;
    logic signed [6:0]  nidx_s;
    logic signed [13:0] sum_s;
    logic signed [11:0] acc_new_s;
    logic [5:0]         idx_new_s;
    logic [5:0]         gain_s;
    logic signed [17:0] acc_ext_s;
    logic signed [17:0] gain_ext_s;
    logic signed [11:0] scaled_s;
    logic [OUT_W-1:0]   aligned_s;

    // A channel still in S1 or S2 has not written its state back yet, so a
    // new nibble for it must wait. Entries in S3 already wrote on the edge
    // that loaded them, so they never block.
    assign in_ready = !((s1_v_r && (s1_ch_r == in_ch)) || (s2_v_r && (s2_ch_r == in_ch)));
    assign accept_s = cen & in_valid & in_ready;

    // S1: fetch channel state (or a clean start) for the step lookup
    always_comb begin
        rd_acc_s = 12'sd0;
        rd_idx_s = 6'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            rd_acc_s = (s1_ch_r == CHW'(i)) ? acc_r[i] : rd_acc_s;
            rd_idx_s = (s1_ch_r == CHW'(i)) ? idx_r[i] : rd_idx_s;
        end
        if (s1_start_r) begin
            s1_acc_s = 12'sd0;
            s1_idx_s = 6'd0;
        end else begin
            s1_acc_s = rd_acc_s;
            s1_idx_s = rd_idx_s;
        end
    end

    // S2: difference, next index, saturated accumulator and clamped index
    always_comb begin
        diff_s = 12'(s2_step_r >> 3)
               + (s2_d_r[2] ? {1'b0, s2_step_r}    : 12'd0)
               + (s2_d_r[1] ? 12'(s2_step_r >> 1)  : 12'd0)
               + (s2_d_r[0] ? 12'(s2_step_r >> 2)  : 12'd0);

        case (s2_d_r[1:0])
            2'd0:    inc_s = 7'sd2;
            2'd1:    inc_s = 7'sd4;
            2'd2:    inc_s = 7'sd6;
            2'd3:    inc_s = 7'sd8;
            default: inc_s = 7'sd2;
        endcase

        nidx_s = s2_d_r[2] ? ($signed({1'b0, s2_idx_r}) + inc_s)
                           : ($signed({1'b0, s2_idx_r}) - 7'sd1);

        if (nidx_s < 7'sd0) begin
            idx_new_s = 6'd0;
        end else if (nidx_s > 7'sd48) begin
            idx_new_s = 6'd48;
        end else begin
            idx_new_s = nidx_s[5:0];
        end

        // 14 bits hold acc +/- diff without wrap, so the clamp sees the true sum
        sum_s = s2_d_r[3] ? (14'(s2_acc_r) - $signed({2'b00, diff_s}))
                          : (14'(s2_acc_r) + $signed({2'b00, diff_s}));

        if (sum_s > 14'sd2047) begin
            acc_new_s = 12'sd2047;
        end else if (sum_s < -14'sd2048) begin
            acc_new_s = 12'sh800;
        end else begin
            acc_new_s = sum_s[11:0];
        end
    end

    // S3 -> S4: attenuate, arithmetic shift, left-align into OUT_W
    always_comb begin
        gain_s     = gain_lut(s3_att_r);
        acc_ext_s  = 18'(s3_acc_r);
        gain_ext_s = $signed({12'd0, gain_s});
        scaled_s   = 12'((acc_ext_s * gain_ext_s) >>> 5);
        aligned_s  = OUT_W'(scaled_s) <<< (OUT_W - 12);
    end

    // Pipeline stage registers; nonexistent channels never become valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r     <= 1'b0;
            s1_start_r <= 1'b0;
            s1_ch_r    <= {CHW{1'b0}};
            s1_d_r     <= 4'd0;
            s1_att_r   <= 4'd0;
            s2_v_r     <= 1'b0;
            s2_ch_r    <= {CHW{1'b0}};
            s2_d_r     <= 4'd0;
            s2_att_r   <= 4'd0;
            s2_acc_r   <= 12'sd0;
            s2_idx_r   <= 6'd0;
            s2_step_r  <= 11'd0;
            s3_v_r     <= 1'b0;
            s3_ch_r    <= {CHW{1'b0}};
            s3_att_r   <= 4'd0;
            s3_acc_r   <= 12'sd0;
            s4_v_r     <= 1'b0;
            s4_ch_r    <= {CHW{1'b0}};
            s4_snd_r   <= {OUT_W{1'b0}};
        end else if (cen) begin
            s1_v_r     <= accept_s && CH_MASK[in_ch];
            s1_start_r <= in_start;
            s1_ch_r    <= in_ch;
            s1_d_r     <= in_data;
            s1_att_r   <= in_att;
            s2_v_r     <= s1_v_r;
            s2_ch_r    <= s1_ch_r;
            s2_d_r     <= s1_d_r;
            s2_att_r   <= s1_att_r;
            s2_acc_r   <= s1_acc_s;
            s2_idx_r   <= s1_idx_s;
            s2_step_r  <= step_lut(s1_idx_s);
            s3_v_r     <= s2_v_r;
            s3_ch_r    <= s2_ch_r;
            s3_att_r   <= s2_att_r;
            s3_acc_r   <= acc_new_s;
            s4_v_r     <= s3_v_r;
            s4_ch_r    <= s3_ch_r;
            s4_snd_r   <= aligned_s;
        end
    end

    // State table writeback on the edge that loads S3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i] <= 12'sd0;
                idx_r[i] <= 6'd0;
            end
        end else if (cen && s2_v_r) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (s2_ch_r == CHW'(i)) begin
                    acc_r[i] <= acc_new_s;
                    idx_r[i] <= idx_new_s;
                end
            end
        end
    end

    // Output registers; channel and sample hold between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= {CHW{1'b0}};
            out_sound <= {OUT_W{1'b0}};
        end else if (cen) begin
            out_valid <= s4_v_r;
            if (s4_v_r) begin
                out_ch    <= s4_ch_r;
                out_sound <= s4_snd_r;
            end
        end
    end

endmodule

// File: tb/tb_jt6295_adpcm_tdm.sv
// ---------------------------------------------------------------------------
// tb_jt6295_adpcm_tdm
// Directed bench for jt6295_adpcm_tdm: reset values, positive/negative
// decoding, attenuation, saturation, hazard stalls, cen gating, round-robin
// throughput against a per-channel reference model, and reset with nibbles
// in flight.
// ---------------------------------------------------------------------------
module tb_jt6295_adpcm_tdm;

    localparam int CHANNELS = 4;
    localparam int CHW      = 2;
    localparam int OUT_W    = 12;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic             cen      = 1'b0;
    logic             in_valid = 1'b0;
    logic [CHW-1:0]   in_ch    = '0;
    logic [3:0]       in_data  = 4'd0;
    logic [3:0]       in_att   = 4'd0;
    logic             in_start = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [CHW-1:0]   out_ch;
    logic [OUT_W-1:0] out_sound;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int acc_cyc  = 0;

    int q_ch[$];
    int q_snd[$];
    int q_cyc[$];

    int m_acc [CHANNELS];
    int m_idx [CHANNELS];

    localparam int STEPS [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                                  73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
                                  253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
                                  876, 963, 1060, 1166, 1282, 1411, 1552};
    localparam int GAINS [16] = '{32, 22, 16, 11, 8, 6, 4, 3, 2, 0, 0, 0, 0, 0, 0, 0};

    jt6295_adpcm_tdm #(.CHANNELS(CHANNELS), .CHW(CHW), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .in_att    (in_att),
        .in_start  (in_start),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_sound (out_sound)
    );

    always #5 clk = ~clk;

    // Count cen cycles and record every output pulse with its cycle number
    always @(posedge clk) begin
        if (cen) begin
            cyc_cnt <= cyc_cnt + 1;
            if (out_valid) begin
                q_ch.push_back(int'(out_ch));
                q_snd.push_back(int'($signed(out_sound)));
                q_cyc.push_back(cyc_cnt);
            end
        end
    end

    // Reference decoder: updates the channel state and returns the sample
    function automatic int model(input int ch, input int d, input int att, input bit start);
        int step, diff, acc, idx;
        if (start) begin
            m_acc[ch] = 0;
            m_idx[ch] = 0;
        end
        step = STEPS[m_idx[ch]];
        diff = step / 8;
        if ((d & 4) != 0) diff += step;
        if ((d & 2) != 0) diff += step / 2;
        if ((d & 1) != 0) diff += step / 4;
        acc = ((d & 8) != 0) ? m_acc[ch] - diff : m_acc[ch] + diff;
        if (acc > 2047) acc = 2047;
        if (acc < -2048) acc = -2048;
        idx = ((d & 4) != 0) ? m_idx[ch] + 2 * ((d & 3) + 1) : m_idx[ch] - 1;
        if (idx < 0) idx = 0;
        if (idx > 48) idx = 48;
        m_acc[ch] = acc;
        m_idx[ch] = idx;
        return ((acc * GAINS[att]) >>> 5) * (1 << (OUT_W - 12));
    endfunction

    task automatic clear_q();
        q_ch.delete();
        q_snd.delete();
        q_cyc.delete();
    endtask

    task automatic pop_out(output int ch, output int snd, output int cy, output bit got);
        if (q_snd.size() == 0) begin
            got = 1'b0; ch = -1; snd = 0; cy = 0;
        end else begin
            got = 1'b1;
            ch  = q_ch.pop_front();
            snd = q_snd.pop_front();
            cy  = q_cyc.pop_front();
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        cen      = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request with cen=1, wait (bounded) for in_ready, count stalls
    task automatic send(input int ch, input int d, input int att, input bit start,
                        output int stalls);
        int guard;
        stalls   = 0;
        guard    = 0;
        cen      = 1'b1;
        in_valid = 1'b1;
        in_ch    = CHW'(ch);
        in_data  = 4'(d);
        in_att   = 4'(att);
        in_start = start;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            stalls++;
            guard++;
            @(posedge clk);
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: ch %0d never ready after %0d cycles", ch, guard);
        end else begin
            void'(model(ch, d, att, start));
            @(posedge clk);
            acc_cyc = cyc_cnt;
            #1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++;
        if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
        checks++;
        if (out_sound !== 12'd0) begin failures++; $display("FAIL reset_out_sound: got %0d want 0", out_sound); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int st, a0, c, s, y;
        bit g;
        clear_q();
        send(0, 7, 0, 1'b1, st);
        a0 = acc_cyc;
        send(0, 0, 0, 1'b0, st);
        idle(8);
        pop_out(c, s, y, g);
        checks++;
        if (!g || s !== 30) begin failures++; $display("FAIL basic_first: got %0d want 30", s); end
        checks++;
        if (!g || c !== 0) begin failures++; $display("FAIL basic_ch: got %0d want 0", c); end
        checks++;
        if (!g || (y - a0) !== 5) begin failures++; $display("FAIL basic_latency: got %0d want 5", y - a0); end
        pop_out(c, s, y, g);
        checks++;
        if (!g || s !== 34) begin failures++; $display("FAIL basic_second: got %0d want 34", s); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drop: out_valid got %0b want 0", out_valid); end
        checks++;
        if (int'($signed(out_sound)) !== 34) begin failures++; $display("FAIL basic_hold: got %0d want 34", $signed(out_sound)); end
    endtask

    task automatic test_negative();
        int st, c, s, y;
        bit g;
        int exp_s [3] = '{-30, 0, -21};
        clear_q();
        send(1, 15, 0, 1'b1, st);
        send(1, 15, 9, 1'b1, st);
        send(1, 15, 1, 1'b1, st);
        idle(8);
        for (int i = 0; i < 3; i++) begin
            pop_out(c, s, y, g);
            checks++;
            if (!g || s !== exp_s[i] || c !== 1) begin
                failures++;
                $display("FAIL negative_%0d: got ch %0d val %0d want ch 1 val %0d", i, c, s, exp_s[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int st, c, s, y;
        bit g;
        int exp_s [12] = '{30, 93, 229, 522, 1153, 2047, 2047, 2047, -863, -2048, -2048, -2048};
        clear_q();
        for (int i = 0; i < 8; i++) send(2, 7, 0, (i == 0), st);
        for (int i = 0; i < 4; i++) send(2, 15, 0, 1'b0, st);
        idle(8);
        for (int i = 0; i < 12; i++) begin
            pop_out(c, s, y, g);
            checks++;
            if (!g || s !== exp_s[i] || c !== 2) begin
                failures++;
                $display("FAIL saturation_%0d: got ch %0d val %0d want ch 2 val %0d", i, c, s, exp_s[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st, c, s, y, prev;
        bit g;
        int exp_c [6] = '{0, 0, 0, 1, 3, 1};
        int exp_s [6] = '{30, 34, 68, 6, 10, 20};
        clear_q();
        send(0, 7, 0, 1'b1, st);
        // Hazard must hold while cen is low
        cen = 1'b0;
        in_data = 4'd0;
        in_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL cen_hold_stall_%0d: in_ready got %0b want 0", i, in_ready); end
        end
        @(posedge clk);
        #1;
        send(0, 0, 0, 1'b0, st);
        checks++;
        if (st !== 2) begin failures++; $display("FAIL b2b_stall_1: got %0d want 2", st); end
        send(0, 4, 0, 1'b0, st);
        checks++;
        if (st !== 2) begin failures++; $display("FAIL b2b_stall_2: got %0d want 2", st); end
        send(1, 1, 0, 1'b1, st);
        send(3, 2, 0, 1'b1, st);
        checks++;
        if (st !== 0) begin failures++; $display("FAIL aba_stall_b: got %0d want 0", st); end
        send(1, 3, 0, 1'b0, st);
        checks++;
        if (st !== 1) begin failures++; $display("FAIL aba_stall_a: got %0d want 1", st); end
        idle(8);
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            pop_out(c, s, y, g);
            checks++;
            if (!g || s !== exp_s[i] || c !== exp_c[i]) begin
                failures++;
                $display("FAIL b2b_out_%0d: got ch %0d val %0d want ch %0d val %0d", i, c, s, exp_c[i], exp_s[i]);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (y - prev !== 3) begin failures++; $display("FAIL b2b_spacing_%0d: got %0d want 3", i, y - prev); end
            end
            prev = y;
        end
    endtask

    task automatic test_round_robin();
        int ch, d, att, c, s, y;
        bit g;
        int exp_c[$];
        int exp_s[$];
        clear_q();
        for (int k = 0; k < 24; k++) begin
            ch = k % CHANNELS;
            d = int'($urandom_range(15, 0));
            att = int'($urandom_range(8, 0));
            cen = 1'b0;
            in_valid = 1'b1;
            in_ch = CHW'(ch);
            in_data = 4'(d);
            in_att = 4'(att);
            in_start = (k < CHANNELS);
            repeat (2) @(posedge clk);
            #1 cen = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rr_ready_%0d: in_ready got %0b want 1", k, in_ready);
            end else begin
                exp_c.push_back(ch);
                exp_s.push_back(model(ch, d, att, (k < CHANNELS)));
            end
            @(posedge clk);
            #1;
        end
        idle(8);
        for (int i = 0; i < exp_s.size(); i++) begin
            pop_out(c, s, y, g);
            checks++;
            if (!g || s !== exp_s[i] || c !== exp_c[i]) begin
                failures++;
                $display("FAIL rr_out_%0d: got ch %0d val %0d want ch %0d val %0d", i, c, s, exp_c[i], exp_s[i]);
            end
        end
        checks++;
        if (q_snd.size() !== 0) begin failures++; $display("FAIL rr_extra: got %0d extra outputs want 0", q_snd.size()); end
    endtask

    task automatic test_reset_inflight();
        int st, c, s, y;
        bit g;
        int exp_s [4] = '{30, 2, 2, 2};
        clear_q();
        send(0, 7, 0, 1'b1, st);
        send(1, 7, 0, 1'b1, st);
        send(2, 7, 0, 1'b1, st);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sound !== 12'd0 || out_ch !== 2'd0) begin
            failures++;
            $display("FAIL inflight_reset_out: got v %0b ch %0d val %0d want 0 0 0", out_valid, out_ch, out_sound);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        checks++;
        if (q_snd.size() !== 0) begin failures++; $display("FAIL inflight_no_out: got %0d pulses want 0", q_snd.size()); end
        for (int i = 0; i < CHANNELS; i++) begin
            m_acc[i] = 0;
            m_idx[i] = 0;
        end
        send(0, 7, 0, 1'b0, st);
        send(1, 0, 0, 1'b0, st);
        send(2, 0, 0, 1'b0, st);
        send(3, 0, 0, 1'b0, st);
        idle(8);
        for (int i = 0; i < 4; i++) begin
            pop_out(c, s, y, g);
            checks++;
            if (!g || s !== exp_s[i] || c !== i) begin
                failures++;
                $display("FAIL inflight_after_%0d: got ch %0d val %0d want ch %0d val %0d", i, c, s, i, exp_s[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < CHANNELS; i++) begin
            m_acc[i] = 0;
            m_idx[i] = 0;
        end
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_back_to_back();
        test_round_robin();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
